// File: rtl/keybank_pkg.sv
// Shared types, default sizes and the beat-width helper for the key bank.
// The ZERO state exists only when KEYBANK_ZEROIZE_EN is defined.
package keybank_pkg;

    localparam int DATA_WIDTH_DEF = 128;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int BEATS_DEF      = 2;

`ifdef KEYBANK_ZEROIZE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2,
        ST_ZERO = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_e;
`endif

    function automatic int beat_bits(input int beats);
        int b;
        b = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < beats) b = i + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/mod_keybank_mem.sv
// Word storage for the key bank: one write port, one async read port,
// every word cleared by reset.
module mod_keybank_mem
    import keybank_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mod_keybank.sv
// Key bank: streams a multi-word key beat by beat over a valid/ready port.
// Optional clear-all command enabled by defining KEYBANK_ZEROIZE_EN.
module mod_keybank
    import keybank_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BEATS      = BEATS_DEF,
    localparam int KEY_W     = ADDR_WIDTH - beat_bits(BEATS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [KEY_W-1:0]      rd_key,
    input  logic                  rd_ready,
`ifdef KEYBANK_ZEROIZE_EN
    input  logic                  zeroize,
`endif
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  done,
    output logic                  busy,
    output logic                  wr_err
);

    localparam int BW  = beat_bits(BEATS);
    localparam int BCW = (BW > 0) ? BW : 1;

    state_e                state_q, state_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic [BCW-1:0]        beat_q, beat_d;
    logic                  data_valid_q, data_valid_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  wr_err_q, wr_err_d;
`ifdef KEYBANK_ZEROIZE_EN
    logic [ADDR_WIDTH-1:0] zaddr_q, zaddr_d;
`endif

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [KEY_W-1:0]      wr_key;
    logic                  last_beat;

    // Key sits above the beat bits, so beat arithmetic never reaches the key.
    assign rd_addr   = (ADDR_WIDTH'(key_q) << BW) | ADDR_WIDTH'(beat_q);
    assign wr_key    = KEY_W'(wr_addr >> BW);
    assign last_beat = (beat_q == BCW'(BEATS - 1));

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        beat_d    = beat_q;
        wr_err_d  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
`ifdef KEYBANK_ZEROIZE_EN
        zaddr_d   = zaddr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                mem_we = wr_en;
                if (rd_req) begin
                    key_d   = rd_key;
                    beat_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (wr_en) begin
                    if (wr_key == key_q) wr_err_d = 1'b1;
                    else                 mem_we   = 1'b1;
                end
                if (rd_ready) begin
                    if (last_beat) state_d = ST_DONE;
                    else           beat_d  = beat_q + BCW'(1);
                end
            end
            ST_DONE: begin
                mem_we  = wr_en;
                state_d = ST_IDLE;
            end
`ifdef KEYBANK_ZEROIZE_EN
            ST_ZERO: begin
                wr_err_d  = wr_en;
                mem_we    = 1'b1;
                mem_waddr = zaddr_q;
                mem_wdata = '0;
                if (zaddr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_DONE;
                else zaddr_d = zaddr_q + ADDR_WIDTH'(1);
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef KEYBANK_ZEROIZE_EN
        // Clear-all wins over everything, including a same-cycle write.
        if (zeroize) begin
            state_d  = ST_ZERO;
            zaddr_d  = '0;
            mem_we   = 1'b0;
            wr_err_d = wr_en;
        end
`endif
        data_valid_d = (state_d == ST_READ);
        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            beat_q       <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            wr_err_q     <= 1'b0;
`ifdef KEYBANK_ZEROIZE_EN
            zaddr_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            beat_q       <= beat_d;
            data_valid_q <= data_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            wr_err_q     <= wr_err_d;
`ifdef KEYBANK_ZEROIZE_EN
            zaddr_q      <= zaddr_d;
`endif
        end
    end

    mod_keybank_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .resetn (resetn),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr  (rd_addr),
        .rdata  (rdata)
    );

    assign data       = data_valid_q ? rdata : '0;
    assign data_valid = data_valid_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_mod_keybank.sv
// Directed bench for mod_keybank: streaming, backpressure, write rules,
// reset; zeroize sequence when KEYBANK_ZEROIZE_EN is defined.
module tb_mod_keybank;

    logic         clk;
    logic         resetn;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [127:0] wr_data;
    logic         rd_req;
    logic [2:0]   rd_key;
    logic         rd_ready;
    logic         zeroize;
    logic [127:0] data;
    logic         data_valid;
    logic         done;
    logic         busy;
    logic         wr_err;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] W0  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] W1  = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] W2  = 128'h2222_0000_2222_0000_2222_0000_2222_0002;
    localparam logic [127:0] W3  = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
    localparam logic [127:0] W6  = 128'h6666_1111_6666_1111_6666_1111_6666_0006;
    localparam logic [127:0] W7  = 128'h7777_1111_7777_1111_7777_1111_7777_0007;
    localparam logic [127:0] BAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] N6  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] A5  = {16{8'hA5}};

    mod_keybank dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_key     (rd_key),
        .rd_ready   (rd_ready),
`ifdef KEYBANK_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .data       (data),
        .data_valid (data_valid),
        .done       (done),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [127:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rd_key   = '0;
        rd_ready = 1'b0;
        zeroize  = 1'b0;
        #2;
        chk("rst_data", data, '0);
        chk("rst_valid", data_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrerr", wr_err, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        wr(4'd0, W0);
        wr(4'd1, W1);
        wr(4'd2, W2);
        wr(4'd3, W3);
        wr(4'd6, W6);
        wr(4'd7, W7);
        chk("wr_idle_noerr", wr_err, 0);

        // key 0 at full rate
        rd_req = 1'b1; rd_key = 3'd0; rd_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("k0_b0_data", data, W0);
        chk("k0_b0_valid", data_valid, 1);
        chk("k0_b0_busy", busy, 1);
        tick();
        chk("k0_b1_data", data, W1);
        chk("k0_b1_done", done, 0);
        tick();
        chk("k0_done", done, 1);
        chk("k0_done_valid", data_valid, 0);
        tick();
        chk("k0_idle_done", done, 0);
        chk("k0_idle_busy", busy, 0);

        // key 3 with backpressure on beat 0
        rd_req = 1'b1; rd_key = 3'd3; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("k3_hold0_data", data, W6);
        tick();
        chk("k3_hold1_data", data, W6);
        chk("k3_hold1_valid", data_valid, 1);
        tick();
        chk("k3_hold2_data", data, W6);
        rd_ready = 1'b1;
        tick();
        chk("k3_b1_data", data, W7);
        tick();
        chk("k3_done", done, 1);
        tick();
        chk("k3_done_once", done, 0);

        // writes during a read of key 1
        rd_req = 1'b1; rd_key = 3'd1; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("k1_b0_data", data, W2);
        wr(4'd2, BAD);
        chk("same_key_wrerr", wr_err, 1);
        chk("same_key_data", data, W2);
        wr(4'd6, N6);
        chk("other_key_wrerr", wr_err, 0);
        chk("other_key_data", data, W2);
        rd_ready = 1'b1;
        tick();
        chk("k1_b1_data", data, W3);
        tick();
        chk("k1_done", done, 1);
        tick();
        rd_req = 1'b1; rd_key = 3'd3;
        tick();
        rd_req = 1'b0;
        chk("k3_new6", data, N6);
        tick();
        tick();
        tick();
        rd_req = 1'b1; rd_key = 3'd1;
        tick();
        rd_req = 1'b0;
        chk("k1_unchanged", data, W2);
        tick();
        tick();
        tick();

        // same-cycle write and read, rd_req held to show it is ignored while busy
        rd_req = 1'b1; rd_key = 3'd2;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = A5;
        tick();
        wr_en = 1'b0;
        rd_key = 3'd0;
        chk("raw_b0_data", data, A5);
        tick();
        chk("raw_b1_data", data, '0);
        rd_req = 1'b0;
        tick();
        chk("raw_done", done, 1);
        tick();
        chk("raw_idle_busy", busy, 0);

        // async reset in the middle of beat 1
        rd_req = 1'b1; rd_key = 3'd0; rd_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_ready = 1'b1;
        tick();
        chk("pre_rst_data", data, W1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_data", data, '0);
        chk("arst_valid", data_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick();
        resetn = 1'b1;
        tick();
        rd_req = 1'b1; rd_key = 3'd3;
        tick();
        rd_req = 1'b0;
        chk("post_rst_k3b0", data, '0);
        chk("post_rst_valid", data_valid, 1);
        tick();
        chk("post_rst_k3b1", data, '0);
        tick();
        tick();
        rd_req = 1'b1; rd_key = 3'd0;
        tick();
        rd_req = 1'b0;
        chk("post_rst_k0b0", data, '0);
        tick();
        tick();
        tick();

`ifdef KEYBANK_ZEROIZE_EN
        for (int i = 0; i < 16; i++) wr(4'(i), {8{16'(i + 1)}});
        rd_req = 1'b1; rd_key = 3'd5; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("z_pre_data", data, {8{16'd11}});
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("z_valid_drop", data_valid, 0);
        for (int i = 0; i < 16; i++) begin
            chk("z_busy", busy, 1);
            chk("z_nodone", done, 0);
            tick();
        end
        chk("z_done", done, 1);
        tick();
        chk("z_idle", busy, 0);
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_req = 1'b1; rd_key = 3'(k);
            tick();
            rd_req = 1'b0;
            chk("z_b0", data, '0);
            tick();
            chk("z_b1", data, '0);
            tick();
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
